// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// rtl/firebird7_in_gate1_tessent_tdr_pkg.sv - shared types and length helper for the IJTAG TDR
package firebird7_in_gate1_tessent_tdr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURED,
      ST_SHIFTING,
      ST_READY
   } tdr_state_e;

   localparam int DEFAULT_WIDTH   = 19;
   localparam int DEFAULT_TDR_LEN = DEFAULT_WIDTH + 2;

   // Scan chain length: data field plus the select and error bits.
   function automatic int tdr_len(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_update_reg.sv
// rtl/firebird7_in_gate1_tessent_tdr_update_reg.sv - update register with shift-length check and sticky error
module firebird7_in_gate1_tessent_tdr_update_reg
   import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
   parameter int WIDTH = 19,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_en,
   input  logic             armed,
   input  logic [CNT_W-1:0] shift_cnt,
   input  logic [WIDTH+1:0] shift_bits,
   output logic [WIDTH-1:0] data_out,
   output logic             select_out,
   output logic             length_error
);

   localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(tdr_len(WIDTH));

   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_q, sel_d;
   logic             err_q, err_d;
   logic             len_ok;

   // Without a capture since the last update the shift counts as length 0.
   assign len_ok = armed && (shift_cnt == LEN_CNT);

   always_comb begin
      data_d = data_q;
      sel_d  = sel_q;
      err_d  = err_q;
      if (upd_en) begin
         if (len_ok) begin
            data_d = shift_bits[WIDTH-1:0];
            sel_d  = shift_bits[WIDTH];
            if (!shift_bits[WIDTH+1]) begin
               err_d = 1'b0;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         sel_q  <= sel_d;
         err_q  <= err_d;
      end
   end

   assign data_out     = data_q;
   assign select_out   = sel_q;
   assign length_error = err_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19.sv
// rtl/firebird7_in_gate1_tessent_tdr_w19.sv - IJTAG TDR with capture/shift/update and length checking
module firebird7_in_gate1_tessent_tdr_w19
   import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
   parameter int WIDTH = 19
) (
   input  logic             ijtag_tck,
   input  logic             ijtag_reset,
   input  logic             ijtag_sel,
   input  logic             ijtag_ce,
   input  logic             ijtag_se,
   input  logic             ijtag_ue,
   input  logic             ijtag_si,
   output logic             ijtag_so,
   input  logic [WIDTH-1:0] capture_data_in,
   output logic [WIDTH-1:0] tdr_data_out,
   output logic             ijtag_select,
   output logic             length_error
);

   localparam int               LEN     = tdr_len(WIDTH);
   localparam int               CNT_MAX = 2 * LEN;
   localparam int               CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LEN);
   localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(CNT_MAX);

   logic [LEN-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   tdr_state_e       state_q, state_d;
   logic             do_capture, do_shift, do_update;

   assign do_capture = ijtag_sel & ijtag_ce;
   assign do_shift   = ijtag_sel & ijtag_se & ~ijtag_ce;
   assign do_update  = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

   always_comb begin
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (do_capture) begin
         sr_d    = {length_error, ijtag_select, capture_data_in};
         cnt_d   = '0;
         state_d = ST_CAPTURED;
      end else if (do_shift) begin
         sr_d = {ijtag_si, sr_q[LEN-1:1]};
         if (cnt_q != SAT_CNT) begin
            cnt_d = cnt_q + 1'b1;
         end
         // Shifting without a prior capture stays IDLE so a later update is rejected.
         if (state_q != ST_IDLE) begin
            state_d = (cnt_d == LEN_CNT) ? ST_READY : ST_SHIFTING;
         end
      end else if (do_update) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign ijtag_so = sr_q[0];

   firebird7_in_gate1_tessent_tdr_update_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_update_reg (
      .clk          (ijtag_tck),
      .rst          (ijtag_reset),
      .upd_en       (do_update),
      .armed        (state_q != ST_IDLE),
      .shift_cnt    (cnt_q),
      .shift_bits   (sr_q),
      .data_out     (tdr_data_out),
      .select_out   (ijtag_select),
      .length_error (length_error)
   );

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv
// tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv - directed bench for the IJTAG TDR
module tb_firebird7_in_gate1_tessent_tdr_w19;

   localparam int WIDTH = 19;
   localparam int LEN   = WIDTH + 2;

   logic             ijtag_tck = 1'b0;
   logic             ijtag_reset;
   logic             ijtag_sel;
   logic             ijtag_ce;
   logic             ijtag_se;
   logic             ijtag_ue;
   logic             ijtag_si;
   logic             ijtag_so;
   logic [WIDTH-1:0] capture_data_in;
   logic [WIDTH-1:0] tdr_data_out;
   logic             ijtag_select;
   logic             length_error;

   int vec_count  = 0;
   int miscompares = 0;

   firebird7_in_gate1_tessent_tdr_w19 #(.WIDTH(WIDTH)) dut (
      .ijtag_tck       (ijtag_tck),
      .ijtag_reset     (ijtag_reset),
      .ijtag_sel       (ijtag_sel),
      .ijtag_ce        (ijtag_ce),
      .ijtag_se        (ijtag_se),
      .ijtag_ue        (ijtag_ue),
      .ijtag_si        (ijtag_si),
      .ijtag_so        (ijtag_so),
      .capture_data_in (capture_data_in),
      .tdr_data_out    (tdr_data_out),
      .ijtag_select    (ijtag_select),
      .length_error    (length_error)
   );

   always #5 ijtag_tck = ~ijtag_tck;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ijtag_tck);
      #1;
   endtask

   task automatic capture(input logic [WIDTH-1:0] d);
      capture_data_in = d;
      ijtag_ce = 1'b1;
      tick();
      ijtag_ce = 1'b0;
   endtask

   task automatic shift_n(input logic [LEN-1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         ijtag_si = v[i];
         ijtag_se = 1'b1;
         tick();
      end
      ijtag_se = 1'b0;
      ijtag_si = 1'b0;
   endtask

   task automatic update();
      ijtag_ue = 1'b1;
      tick();
      ijtag_ue = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [WIDTH-1:0] d, input logic s, input logic e);
      check_vec({tag, "_data"}, 32'(tdr_data_out), 32'(d));
      check_vec({tag, "_sel"},  32'(ijtag_select), 32'(s));
      check_vec({tag, "_err"},  32'(length_error), 32'(e));
   endtask

   logic [LEN-1:0] v;

   initial begin
      ijtag_reset = 1'b1;
      ijtag_sel = 1'b1;
      ijtag_ce = 1'b0;
      ijtag_se = 1'b0;
      ijtag_ue = 1'b0;
      ijtag_si = 1'b0;
      capture_data_in = '0;
      tick();
      tick();
      ijtag_reset = 1'b0;
      check_out("reset", 19'h0, 1'b0, 1'b0);
      check_vec("reset_so", 32'(ijtag_so), 32'h0);

      // Capture and scan out: data LSB-first, then sel, then err.
      capture(19'h5A5A5);
      v = {1'b0, 1'b0, 19'h5A5A5};
      for (int i = 0; i < LEN; i++) begin
         check_vec($sformatf("so_bit%0d", i), 32'(ijtag_so), 32'(v[i]));
         ijtag_si = 1'b0;
         ijtag_se = 1'b1;
         tick();
         ijtag_se = 1'b0;
      end

      // Correct-length load of all-ones data with select set.
      capture(19'h0);
      shift_n({1'b0, 1'b1, 19'h7FFFF}, LEN);
      check_out("pre_upd", 19'h0, 1'b0, 1'b0);
      update();
      check_out("upd_ones", 19'h7FFFF, 1'b1, 1'b0);

      // Short shift is rejected, then a good load clears the error.
      capture(19'h0);
      shift_n({1'b0, 1'b0, 19'h12345}, LEN - 1);
      update();
      check_out("short", 19'h7FFFF, 1'b1, 1'b1);
      capture(19'h0);
      shift_n({1'b0, 1'b0, 19'h12345}, LEN);
      update();
      check_out("recover", 19'h12345, 1'b0, 1'b0);

      // Update with no capture is length 0; err bit 1 on a good load keeps the flag.
      update();
      check_out("no_cap", 19'h12345, 1'b0, 1'b1);
      capture(19'h0);
      shift_n({1'b1, 1'b1, 19'h00F0F}, LEN);
      update();
      check_out("err_keep", 19'h00F0F, 1'b1, 1'b1);

      // All enables together: capture wins, counter restarts from zero.
      capture_data_in = 19'h15555;
      ijtag_ce = 1'b1;
      ijtag_se = 1'b1;
      ijtag_ue = 1'b1;
      tick();
      ijtag_ce = 1'b0;
      ijtag_se = 1'b0;
      ijtag_ue = 1'b0;
      check_out("prio", 19'h00F0F, 1'b1, 1'b1);
      check_vec("prio_so", 32'(ijtag_so), 32'h1);
      shift_n({1'b0, 1'b0, 19'h0ABCD}, LEN);
      update();
      check_out("prio_cnt", 19'h0ABCD, 1'b0, 1'b0);

      // Deselected: enables must have no effect on anything.
      capture(19'h0);
      shift_n({1'b0, 1'b1, 19'h33333}, LEN);
      check_vec("desel_pre_so", 32'(ijtag_so), 32'h1);
      ijtag_sel = 1'b0;
      for (int i = 0; i < 30; i++) begin
         ijtag_se = 1'b1;
         ijtag_si = 1'b0;
         ijtag_ce = (i == 10);
         ijtag_ue = (i == 20);
         tick();
      end
      ijtag_se = 1'b0;
      ijtag_ce = 1'b0;
      ijtag_ue = 1'b0;
      check_vec("desel_so", 32'(ijtag_so), 32'h1);
      check_out("desel", 19'h0ABCD, 1'b0, 1'b0);
      ijtag_sel = 1'b1;
      update();
      check_out("desel_upd", 19'h33333, 1'b1, 1'b0);

      // Reset in the middle of a shift overrides the enable.
      capture(19'h0);
      shift_n({LEN{1'b1}}, 10);
      ijtag_reset = 1'b1;
      ijtag_se = 1'b1;
      ijtag_si = 1'b1;
      tick();
      ijtag_reset = 1'b0;
      ijtag_se = 1'b0;
      ijtag_si = 1'b0;
      check_out("mid_rst", 19'h0, 1'b0, 1'b0);
      check_vec("mid_rst_so", 32'(ijtag_so), 32'h0);
      update();
      check_out("rst_upd", 19'h0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_w19.md
FIREBIRD7_IN_GATE1_TESSENT_TDR_W19 -- requirements
Module: firebird7_in_gate1_tessent_tdr_w19

Interface
REQ-001 Parameter WIDTH, default 19, shall set the data field width of the register.
REQ-002 Port ijtag_tck, input, 1: sole clock; all state shall update on its rising edge.
REQ-003 Port ijtag_reset, input, 1: reset, synchronous, active-high.
REQ-004 Port ijtag_sel, input, 1: the network selects this TDR; ce/se/ue shall be ignored when it is low.
REQ-005 Port ijtag_ce, input, 1: capture enable.
REQ-006 Port ijtag_se, input, 1: shift enable.
REQ-007 Port ijtag_ue, input, 1: update enable.
REQ-008 Port ijtag_si, input, 1: scan in.
REQ-009 Port ijtag_so, output, 1: scan out, equal to shift-register bit 0.
REQ-010 Port capture_data_in, input, WIDTH: functional observe value, loaded on capture.
REQ-011 Port tdr_data_out, output, WIDTH: update-register data field; drives the data mux ijtag_data_in.
REQ-012 Port ijtag_select, output, 1: update-register select bit; drives the data mux select.
REQ-013 Port length_error, output, 1: sticky flag set when an update follows a wrong-length shift.

Function
REQ-014 The shift register shall be WIDTH+2 bits: [WIDTH+1]=err, [WIDTH]=sel, [WIDTH-1:0]=data. Bit 0 shifts out first.
REQ-015 Capture (sel&ce) shall load {length_error, ijtag_select, capture_data_in} and clear the shift counter.
REQ-016 Shift (sel&se&!ce) shall move the register right one bit, load ijtag_si into the MSB, and increment the shift counter, saturating at 2*(WIDTH+2).
REQ-017 Update (sel&ue&!ce&!se) shall load sel and data from the shift register only when the shift counter is exactly WIDTH+2. Otherwise the update register shall hold and length_error shall be set.
REQ-018 An update whose err bit (shift bit WIDTH+1) is 0 with a correct length shall clear length_error. A value of 1 shall leave it unchanged.
REQ-019 Priority shall be ce > se > ue for simultaneous enables. Any lower-priority enable shall be ignored that cycle.
REQ-020 The FSM shall have states IDLE, CAPTURED, SHIFTING and READY:
- capture shall go to CAPTURED;
- the first shift shall go to SHIFTING;
- the counter reaching WIDTH+2 shall go to READY;
- a further shift shall go back to SHIFTING;
- update shall go to IDLE.
REQ-021 An update in IDLE (no capture since the last update) shall be treated as length 0, and shall therefore set length_error.
REQ-022 tdr_data_out and ijtag_select shall change only on a valid update, and shall be registered (one cycle after the ue edge).
REQ-023 ijtag_so shall be valid in the cycle after capture and after each shift.

Reset
REQ-024 On ijtag_reset the following shall clear to 0: shift register, counter, tdr_data_out, ijtag_select and length_error. The FSM shall go to IDLE.
REQ-025 Reset shall override all enables in the same cycle, including reset asserted mid-shift.
REQ-026 The first valid operation after reset shall be a capture.

Structure
REQ-027 The FSM state enum and a TDR length localparam function of WIDTH shall be placed in the package firebird7_in_gate1_tessent_tdr_pkg.
REQ-028 The update register plus its validity check shall be one sub-module, firebird7_in_gate1_tessent_tdr_update_reg. Everything else shall be flat.

Verification
REQ-029 The bench shall cover each of the following directed scenarios:
- Reset; capture 0x5A5A5; shift 21 bits -> so sequence is 0x5A5A5 LSB-first, then sel=0, then err=0.
- Capture; shift in {err=0, sel=1, data=0x7FFFF} (21 bits); update -> one cycle later tdr_data_out=0x7FFFF, ijtag_select=1, length_error=0.
- Capture; shift 20 bits; update -> outputs hold previous value and length_error=1; then a correct 21-bit cycle with err=0 -> length_error=0.
- ce, se and ue high together with sel=1 -> capture only; counter=0; outputs unchanged.
- sel=0 with se pulses for 30 cycles -> shift register, counter and outputs unchanged.
- Reset asserted after 10 shifts -> all outputs 0 next cycle; a following update without capture sets length_error=1.
